uart_frame_packer: RTL and testbench

- Sits between the UART receiver and the neural-network core.
- Collects the byte stream from the receiver into NUM_WORDS little-endian words of WORD_W bits.
- Presents the full frame on a flattened bus with a valid/ready handshake, so the controller starts the network only on a complete frame.
- An inter-byte idle timeout resynchronises on a broken partial frame.

---
 rtl/uart_frame_packer.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_frame_packer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: assembles the UART byte stream into a frame of NUM_WORDS
// little-endian words and offers it to the network core with valid/ready.
// Byte n of a frame lands at frame_data[8n +: 8] (word n/(WORD_W/8), lane
// n%(WORD_W/8)). A partial frame idle for IDLE_TIMEOUT cycles is discarded.
// Optional feature macro: FRAME_CHECKSUM_EN -- adds a trailing XOR checksum
// byte checked in a CHECK state, reported on chk_err. When the macro is
// undefined chk_err is tied low and no checksum logic exists.
module uart_frame_packer #(
  parameter int NUM_WORDS    = 9,
  parameter int WORD_W       = 32,
  parameter int IDLE_TIMEOUT = 200000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  output logic [NUM_WORDS*WORD_W-1:0] frame_data,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        overrun_err,
  output logic                        chk_err
);

  localparam int FW    = NUM_WORDS * WORD_W;
  localparam int TOTAL = FW / 8;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int IW    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [IW-1:0]   idle_inc_s;
  logic [FW-1:0]   data_q, data_d;
  logic            accept_s;
  logic            timeout_s;
  logic            overrun_s;

  logic            frame_valid_q, frame_valid_d;
  logic            busy_q, busy_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_err_q, overrun_err_d;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0]      xor_q, xor_d;
  logic            chk_s;
  logic            chk_err_q, chk_err_d;
`endif

  assign idle_inc_s = idle_q + IW'(1);

  // State register plus frame datapath registers (byte counter, idle counter, frame buffer).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
`ifdef FRAME_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  // Next-state logic: byte acceptance, idle timeout, hold/handshake and overrun detection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    data_d    = data_q;
    accept_s  = 1'b0;
    timeout_s = 1'b0;
    overrun_s = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    xor_d     = xor_q;
    chk_s     = 1'b0;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (rx_valid) begin
          accept_s = 1'b1;
        end else if (cnt_q != '0) begin
          if (IDLE_TIMEOUT != 0) begin
            if (idle_inc_s == IW'(IDLE_TIMEOUT)) begin
              cnt_d     = '0;
              idle_d    = '0;
              timeout_s = 1'b1;
`ifdef FRAME_CHECKSUM_EN
              xor_d     = 8'h00;
`endif
            end else begin
              idle_d = idle_inc_s;
            end
          end else begin
            idle_d = idle_q;
          end
        end else begin
          idle_d = '0;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid) begin
          idle_d = '0;
          xor_d  = 8'h00;
          if (rx_byte == xor_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
            chk_s   = 1'b1;
          end
        end else if (IDLE_TIMEOUT != 0) begin
          if (idle_inc_s == IW'(IDLE_TIMEOUT)) begin
            state_d   = ST_COLLECT;
            idle_d    = '0;
            timeout_s = 1'b1;
            xor_d     = 8'h00;
          end else begin
            idle_d = idle_inc_s;
          end
        end else begin
          idle_d = idle_q;
        end
      end
`endif
      ST_HOLD: begin
        if (frame_ready) begin
          // Handshake: a byte arriving now starts the next frame.
          state_d  = ST_COLLECT;
          accept_s = rx_valid;
        end else if (rx_valid) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase

    if (accept_s) begin
      idle_d = '0;
      for (int n = 0; n < TOTAL; n++) begin
        if (cnt_q == CW'(n)) begin
          data_d[n*8 +: 8] = rx_byte;
        end else begin
          data_d[n*8 +: 8] = data_d[n*8 +: 8];
        end
      end
`ifdef FRAME_CHECKSUM_EN
      xor_d = (cnt_q == '0) ? rx_byte : (xor_q ^ rx_byte);
`endif
      if (cnt_q == CW'(TOTAL - 1)) begin
        cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
        state_d = ST_CHECK;
`else
        state_d = ST_HOLD;
`endif
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      idle_d = idle_d;
    end
  end

  // Output decode: next values of the registered status and error outputs.
  always_comb begin
    frame_valid_d = (state_d == ST_HOLD);
    busy_d        = ((state_d == ST_COLLECT) && (cnt_d != '0)) || (state_d == ST_CHECK);
    timeout_err_d = timeout_s;
    overrun_err_d = overrun_s;
`ifdef FRAME_CHECKSUM_EN
    chk_err_d     = chk_s;
`endif
  end

  // Output registers so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk_err_q     <= 1'b0;
`endif
    end else begin
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef FRAME_CHECKSUM_EN
      chk_err_q     <= chk_err_d;
`endif
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
`ifdef FRAME_CHECKSUM_EN
  assign chk_err     = chk_err_q;
`else
  assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_packer.sv
// Self-checking bench for uart_frame_packer with IDLE_TIMEOUT=50.
// Expected frames are built from a byte array by the word/lane packing rule.
module tb_uart_frame_packer;
  localparam int NUM_WORDS    = 9;
  localparam int WORD_W       = 32;
  localparam int IDLE_TIMEOUT = 50;
  localparam int BPW          = WORD_W / 8;
  localparam int TOTAL        = NUM_WORDS * BPW;
  localparam int FW           = NUM_WORDS * WORD_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic          frame_ready;
  logic          busy;
  logic          timeout_err;
  logic          overrun_err;
  logic          chk_err;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  logic [7:0] fb [TOTAL];

  uart_frame_packer #(
    .NUM_WORDS(NUM_WORDS), .WORD_W(WORD_W), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .timeout_err(timeout_err), .overrun_err(overrun_err), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun_err === 1'b1) ovr_cnt++;

  function automatic logic [FW-1:0] expected_frame();
    logic [FW-1:0] f;
    logic [WORD_W-1:0] w;
    f = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w = '0;
      for (int l = BPW - 1; l >= 0; l--) w = (w << 8) | WORD_W'(fb[k*BPW + l]);
      f[k*WORD_W +: WORD_W] = w;
    end
    return f;
  endfunction

  task automatic strobe(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < TOTAL; i++) fb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_bytes(input int first, input int last_excl, input int max_gap);
    for (int i = first; i < last_excl; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      strobe(fb[i]);
    end
  endtask

  task automatic send_check_byte();
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < TOTAL; i++) x = x ^ fb[i];
    strobe(x);
`else
    rx_valid = 1'b0;
`endif
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_valid, busy, timeout_err, overrun_err, chk_err} !== 5'b0 || frame_data !== '0) begin
      failures++;
      $display("FAIL reset_state: got flags=%b data=%h expected all zero",
               {frame_valid, busy, timeout_err, overrun_err, chk_err}, frame_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < TOTAL; i++) fb[i] = 8'(i);
    send_bytes(0, TOTAL - 1, 0);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fill_before_last: got valid=%b busy=%b expected valid=0 busy=1", frame_valid, busy);
    end
    strobe(fb[TOTAL-1]);
    send_check_byte();
    checks++;
    if (frame_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_valid: got valid=%b busy=%b expected valid=1 busy=0", frame_valid, busy);
    end
    checks++;
    if (frame_data[31:0] !== 32'h03020100 || frame_data[8*WORD_W +: WORD_W] !== 32'h23222120) begin
      failures++;
      $display("FAIL fill_words: got w0=%h w8=%h expected 03020100 23222120",
               frame_data[31:0], frame_data[8*WORD_W +: WORD_W]);
    end
    checks++;
    if (frame_data !== expected_frame()) begin
      failures++;
      $display("FAIL fill_frame: got %h expected %h", frame_data, expected_frame());
    end
  endtask

  task automatic test_overrun();
    logic [FW-1:0] held;
    int ovr0;
    held = expected_frame();
    ovr0 = ovr_cnt;
    strobe(8'h55);
    checks++;
    if (overrun_err !== 1'b1 || frame_valid !== 1'b1 || frame_data !== held) begin
      failures++;
      $display("FAIL overrun_pulse: got ovr=%b valid=%b data=%h expected ovr=1 valid=1 data=%h",
               overrun_err, frame_valid, frame_data, held);
    end
    @(negedge clk);
    handshake();
    checks++;
    if (frame_valid !== 1'b0 || (ovr_cnt - ovr0) != 1 || frame_data !== held) begin
      failures++;
      $display("FAIL overrun_handshake: got valid=%b overruns=%0d data=%h expected valid=0 overruns=1 data=%h",
               frame_valid, ovr_cnt - ovr0, frame_data, held);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic seen;
    fill_random();
    send_bytes(0, 5, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_busy: got %b expected 1", busy);
    end
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != IDLE_TIMEOUT || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_latency: got cycles=%0d busy=%b expected cycles=%0d busy=0", cyc, busy, IDLE_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: got %b expected 0", timeout_err);
    end
    // New frame with a byte arriving exactly when the idle count would expire.
    fill_random();
    send_bytes(0, 5, 0);
    seen = 1'b0;
    repeat (IDLE_TIMEOUT - 1) begin
      @(negedge clk);
      if (timeout_err === 1'b1) seen = 1'b1;
    end
    strobe(fb[5]);
    checks++;
    if (seen || timeout_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_byte_wins: got seen=%b tmo=%b busy=%b expected 0 0 1", seen, timeout_err, busy);
    end
    send_bytes(6, TOTAL, 3);
    send_check_byte();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== expected_frame()) begin
      failures++;
      $display("FAIL timeout_next_frame: got valid=%b data=%h expected valid=1 data=%h",
               frame_valid, frame_data, expected_frame());
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    fill_random();
    send_bytes(0, 20, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0 || frame_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_clear: got busy=%b valid=%b data=%h expected 0 0 0", busy, frame_valid, frame_data);
    end
    fill_random();
    send_bytes(0, TOTAL - 1, 1);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_early_valid: got %b expected 0", frame_valid);
    end
    strobe(fb[TOTAL-1]);
    send_check_byte();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== expected_frame()) begin
      failures++;
      $display("FAIL reset_mid_frame: got valid=%b data=%h expected valid=1 data=%h",
               frame_valid, frame_data, expected_frame());
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int ovr0;
    ovr0 = ovr_cnt;
    frame_ready = 1'b1;
    fill_random();
    send_bytes(0, TOTAL, 0);
    send_check_byte();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== expected_frame()) begin
      failures++;
      $display("FAIL b2b_frame1: got valid=%b data=%h expected valid=1 data=%h",
               frame_valid, frame_data, expected_frame());
    end
    fill_random();
    strobe(fb[0]);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_byte: got valid=%b busy=%b expected valid=0 busy=1", frame_valid, busy);
    end
    send_bytes(1, TOTAL, 0);
    send_check_byte();
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== expected_frame() || ovr_cnt != ovr0) begin
      failures++;
      $display("FAIL b2b_frame2: got valid=%b overruns=%0d data=%h expected valid=1 overruns=0 data=%h",
               frame_valid, ovr_cnt - ovr0, frame_data, expected_frame());
    end
    @(negedge clk);
    frame_ready = 1'b0;
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release: got valid=%b expected 0", frame_valid);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_bytes(0, TOTAL, 8);
      send_check_byte();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      checks++;
      if (frame_valid !== 1'b1 || frame_data !== expected_frame()) begin
        failures++;
        $display("FAIL random_frame%0d: got valid=%b data=%h expected valid=1 data=%h",
                 f, frame_valid, frame_data, expected_frame());
      end
      handshake();
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < TOTAL; i++) fb[i] = 8'(i);
    send_bytes(0, TOTAL, 0);
    strobe(8'h00);
    checks++;
    if (frame_valid !== 1'b1 || chk_err !== 1'b0) begin
      failures++;
      $display("FAIL checksum_good: got valid=%b chk=%b expected 1 0", frame_valid, chk_err);
    end
    handshake();
    send_bytes(0, TOTAL, 0);
    strobe(8'h01);
    checks++;
    if (frame_valid !== 1'b0 || chk_err !== 1'b1) begin
      failures++;
      $display("FAIL checksum_bad: got valid=%b chk=%b expected 0 1", frame_valid, chk_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random_frames();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
